// File: rtl/spi_ram.sv
// Byte RAM behind the SPI slave: decodes one {cmd, payload} word per rx_valid rising edge.
// Optional macro SPI_RAM_AUTOINC_EN: post-increment wr_addr/rd_addr after each data access.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE:0]   DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 rx_valid_d;
    logic                 cmd_stb;
    cmd_t                 cmd;
    logic [ADDR_SIZE-1:0] payload;

    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return ({1'b0, a} < DEPTH);
    endfunction

    // Wraps at the last legal word; out-of-range addresses simply roll over the address width.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    assign cmd_stb = rx_valid & ~rx_valid_d;
    assign cmd     = cmd_t'(din[9:8]);
    assign payload = din[ADDR_SIZE-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_d <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            dout       <= '0;
            tx_valid   <= 1'b0;
        end else begin
            rx_valid_d <= rx_valid;
            if (cmd_stb) begin
                tx_valid <= 1'b0;
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= payload;
                    CMD_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                        wr_addr <= next_addr(wr_addr);
`else
                        wr_addr <= wr_addr;
`endif
                    end
                    CMD_RD_ADDR: rd_addr <= payload;
                    CMD_RD_DATA: begin
                        dout     <= in_range(rd_addr) ? mem[rd_addr[MEM_AW-1:0]] : 8'h00;
                        tx_valid <= 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                        rd_addr  <= next_addr(rd_addr);
`else
                        rd_addr  <= rd_addr;
`endif
                    end
                    default: tx_valid <= 1'b0;
                endcase
            end
        end
    end

    // Array is deliberately not reset; the rst_n term keeps a strobe seen during reset from writing.
    always_ff @(posedge clk) begin
        if (rst_n && cmd_stb && (cmd == CMD_WR_DATA) && in_range(wr_addr))
            mem[wr_addr[MEM_AW-1:0]] <= din[7:0];
    end

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram (MEM_DEPTH=128); expectations adapt to SPI_RAM_AUTOINC_EN.
module tb_spi_ram;

    localparam logic [1:0] WA = 2'b00, WD = 2'b01, RA = 2'b10, RD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_a, exp_b;

    spi_ram #(.MEM_DEPTH(128), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One-cycle rx_valid pulse; returns on the negedge after the executing posedge.
    task automatic send(input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        din      = {c, p};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_dout", dout, 8'h00);
        check("rst_txv", {7'b0, tx_valid}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // write/read round trip
        send(WA, 8'h05);
        send(WD, 8'hA5);
        send(RA, 8'h05);
        send(RD, 8'h00);
        check("t1_dout", dout, 8'hA5);
        check("t1_txv", {7'b0, tx_valid}, 8'h01);

        // another command clears tx_valid, dout holds
        send(WA, 8'h00);
        check("t3_txv", {7'b0, tx_valid}, 8'h00);
        check("t3_dout", dout, 8'hA5);
        repeat (3) @(negedge clk);
        check("idle_dout", dout, 8'hA5);
        check("idle_txv", {7'b0, tx_valid}, 8'h00);

        // back-to-back reads
        send(WA, 8'h06);
        send(WD, 8'h5A);
        send(RA, 8'h05);
        send(RD, 8'h00);
        check("bb1_dout", dout, 8'hA5);
        send(RD, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
        exp_a = 8'h5A;
`else
        exp_a = 8'hA5;
`endif
        check("bb2_dout", dout, exp_a);
        check("bb2_txv", {7'b0, tx_valid}, 8'h01);

        // long rx_valid: one write only, later din changes ignored
        send(WA, 8'h10);
        @(negedge clk);
        din      = {WD, 8'h3C};
        rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        din = {WD, 8'h99};
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
`ifdef SPI_RAM_AUTOINC_EN
        exp_a = 8'h11;
`else
        exp_a = 8'h10;
`endif
        check("t2_wr_addr", dut.wr_addr, exp_a);
        send(RA, 8'h10);
        send(RD, 8'h00);
        check("t2_mem10", dout, 8'h3C);

        // out of range with MEM_DEPTH=128
        send(WA, 8'h90);
        send(WD, 8'h77);
        send(RA, 8'h90);
        send(RD, 8'h00);
        check("t5_dout", dout, 8'h00);
        check("t5_txv", {7'b0, tx_valid}, 8'h01);
        send(RA, 8'h10);
        send(RD, 8'h00);
        check("t5_mem10", dout, 8'h3C);

        // wrap at the last word
        send(WA, 8'h7F);
        send(WD, 8'h11);
        send(WD, 8'h22);
        send(RA, 8'h7F);
        send(RD, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
        exp_a = 8'h11;
`else
        exp_a = 8'h22;
`endif
        check("t6_rd1", dout, exp_a);
        send(RD, 8'h00);
        check("t6_rd2", dout, 8'h22);
        send(WA, 8'hFF);
        send(WD, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
        exp_b = 8'h00;
`else
        exp_b = 8'hFF;
`endif
        check("t6_oor_wrap", dut.wr_addr, exp_b);

        // async reset during a held read
        send(RA, 8'h05);
        @(negedge clk);
        din      = {RD, 8'h00};
        rx_valid = 1'b1;
        @(posedge clk);
        #2;
        check("t4_pre_txv", {7'b0, tx_valid}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("t4_dout", dout, 8'h00);
        check("t4_txv", {7'b0, tx_valid}, 8'h00);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t4_rd_addr", dut.rd_addr, 8'h00);
        check("t4_wr_addr", dut.wr_addr, 8'h00);
        @(negedge clk);
        check("t4_post_txv", {7'b0, tx_valid}, 8'h00);
        send(RA, 8'h05);
        send(RD, 8'h00);
        check("t4_mem_kept", dout, 8'hA5);
        check("t4_post_rd_txv", {7'b0, tx_valid}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
